spi_subordinate: RTL
====================

// Module: spi_subordinate
// PURPOSE
//  SPI mode-0 subordinate (receiving end) for spi_master: oversamples SCK/CS/MOSI on the system clock.
//  Shifts in MOSI MSB-first into rx_data. Shifts out a preloaded tx byte on MISO.
//  Supports back-to-back bytes within one CS-low frame. Sits between the SPI pins and a register/CPU side.
// PARAMETERS
//  DATA_W       8   bits per SPI word
//  SYNC_STAGES  2   synchronizer flops on SCK, CS, MOSI (>=2)
// PORTS
//  clk       in   1       system clock; SCK frequency <= clk/4
//  reset     in   1       asynchronous, active-low reset
//  SCK       in   1       SPI clock from master, idle low
//  CS        in   1       chip select, active low
//  MOSI      in   1       serial data from master
//  MISO      out  1       serial data to master
//  tx_data   in   DATA_W  next word to send
//  tx_load   in   1       1-cycle strobe: capture tx_data into tx buffer
//  tx_ready  out  1       tx buffer empty, may be loaded
//  rx_data   out  DATA_W  last complete received word
//  rx_valid  out  1       1-cycle pulse, rx_data updated
//  overrun   out  1       sticky: rx word completed while previous rx_valid not acknowledged (rx_ack)
//  rx_ack    in   1       consumer read rx_data; clears pending flag
//  frame_err out  1       1-cycle pulse: CS deasserted mid-word
//  busy      out  1       high while CS frame active
// BEHAVIOUR
//  Reset: MISO=0, tx_ready=1, rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0, state IDLE, bit_cnt=0.
//  Inputs pass SYNC_STAGES flops; edge detect on synced SCK/CS gives sck_rise, sck_fall, cs_fall, cs_rise
//   (1 clk pulses, latency SYNC_STAGES+1 clk from pin).
//  FSM states IDLE, SHIFT, DONE:
//   IDLE: MISO=0, busy=0. cs_fall -> SHIFT; tx_shift <= tx buffer (or 0 if tx_ready=1, i.e. empty); tx_ready<=1;
//    MISO <= tx_shift MSB same cycle as load; bit_cnt<=0.
//   SHIFT: sck_rise: rx_shift <= {rx_shift[DATA_W-2:0], MOSI_sync}; bit_cnt++.
//    sck_fall: tx_shift <<= 1, MISO <= new MSB; if bit_cnt==0 (word boundary) reload tx_shift from buffer first.
//    sck_rise with bit_cnt==DATA_W-1 -> DONE; bit_cnt wraps to 0.
//   DONE (1 clk): rx_data <= completed word, rx_valid=1; if pending flag already set, overrun<=1; pending<=1;
//    -> SHIFT if CS still low, else IDLE.
//  rx_ack clears pending; overrun clears only on reset or rx_ack with pending=0.
//  cs_rise in SHIFT with bit_cnt!=0: discard partial word, frame_err pulse, -> IDLE. cs_rise with bit_cnt==0 -> IDLE silently.
//  cs_rise and sck_rise same clk: sck_rise is processed first, then CS.
//  tx_load with tx_ready=0: ignored (buffer not overwritten). tx_load on same clk as buffer consume: load wins, tx_ready=0.
//  Reset mid-frame: everything returns to reset values immediately; the frame continues only after a new cs_fall.
//  bit_cnt width $clog2(DATA_W); all counters wrap naturally, no saturation.
// STRUCTURE
//  spi_pkg: spi_sub_state_t enum {IDLE,SHIFT,DONE}, SPI_MODE0 constant, default DATA_W.
//  Sub-module spi_pin_sync: SYNC_STAGES synchronizer + rise/fall detect, instanced for SCK and CS (MOSI sync only).
//  Top: FSM, rx/tx shift registers, tx buffer, flags.
// TESTING
//  1 Loopback: spi_master data_in=8'hA5 -> rx_data=8'hA5, rx_valid one pulse; master data_out = preloaded tx 8'h3C.
//  2 Back-to-back: 2 words 8'h01,8'hFF in one CS frame, rx_ack after each -> two rx_valid pulses, overrun=0.
//  3 Overrun: 2 words with no rx_ack -> overrun=1 after second word, rx_data=second word.
//  4 Empty tx: no tx_load before frame -> MISO shifts 8'h00, tx_ready stays 1.
//  5 Abort: CS high after 3 SCK rises -> frame_err one pulse, rx_valid never, next frame 8'h5A received clean.
//  6 Reset mid-frame after 4 bits -> all outputs reset values; following full frame 8'hC3 received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI subordinate
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_sub_state_t;

    localparam int SPI_MODE0  = 0;
    localparam int SPI_DATA_W = 8;

endpackage

// File: rtl/spi_subordinate_if.sv
// rtl/spi_subordinate_if.sv - SPI pins plus register-side rx/tx handshake
interface spi_subordinate_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
);
    logic              SCK;
    logic              CS;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              overrun;
    logic              rx_ack;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  SCK, CS, MOSI, tx_data, tx_load, rx_ack,
        output MISO, tx_ready, rx_data, rx_valid, overrun, frame_err, busy
    );

    modport master (
        output SCK, CS, MOSI, tx_data, tx_load, rx_ack,
        input  MISO, tx_ready, rx_data, rx_valid, overrun, frame_err, busy
    );
endinterface

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - multi-flop synchronizer with registered rise/fall pulses
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;

    // Flops reset low so a pin already low at reset release never looks like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev   <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev   <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~prev;
            fall   <= ~sync_q[SYNC_STAGES-1] & prev;
        end
    end
endmodule

// File: rtl/spi_subordinate.sv
// rtl/spi_subordinate.sv - SPI mode-0 subordinate: FSM, shift registers, tx buffer, flags
module spi_subordinate
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    spi_subordinate_if.slave    bus
);
    localparam int                CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES:0] mosi_q;
    logic mosi_lvl;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(clk), .reset(reset), .pin(bus.SCK), .rise(sck_rise), .fall(sck_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .reset(reset), .pin(bus.CS), .rise(cs_rise), .fall(cs_fall)
    );

    // One extra flop keeps MOSI aligned with the registered SCK edge pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mosi_q <= '0;
        else        mosi_q <= {mosi_q[SYNC_STAGES-1:0], bus.MOSI};
    end
    assign mosi_lvl = mosi_q[SYNC_STAGES];

    spi_sub_state_t     state, state_n;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0]  rx_shift, rx_shift_n, tx_shift, tx_shift_n;
    logic [DATA_W-1:0]  tx_buf, tx_buf_n, rx_data_q, rx_data_n, buf_word;
    logic tx_ready_q, tx_ready_n, rx_valid_q, rx_valid_n;
    logic pending, pending_n, overrun_q, overrun_n, frame_err_q, frame_err_n;
    logic cs_high, cs_high_n, consume;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            rx_data_q   <= '0;
            tx_ready_q  <= 1'b1;
            rx_valid_q  <= 1'b0;
            pending     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            cs_high     <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            rx_shift    <= rx_shift_n;
            tx_shift    <= tx_shift_n;
            tx_buf      <= tx_buf_n;
            rx_data_q   <= rx_data_n;
            tx_ready_q  <= tx_ready_n;
            rx_valid_q  <= rx_valid_n;
            pending     <= pending_n;
            overrun_q   <= overrun_n;
            frame_err_q <= frame_err_n;
            cs_high     <= cs_high_n;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        rx_shift_n  = rx_shift;
        tx_shift_n  = tx_shift;
        tx_buf_n    = tx_buf;
        rx_data_n   = rx_data_q;
        tx_ready_n  = tx_ready_q;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;
        pending_n   = pending;
        overrun_n   = overrun_q;
        consume     = 1'b0;
        cs_high_n   = cs_rise ? 1'b1 : (cs_fall ? 1'b0 : cs_high);
        buf_word    = tx_ready_q ? '0 : tx_buf;

        unique case (state)
            IDLE: begin
                tx_shift_n = '0;
                if (cs_fall) begin
                    state_n    = SHIFT;
                    tx_shift_n = buf_word;
                    bit_cnt_n  = '0;
                    consume    = 1'b1;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    rx_shift_n = {rx_shift[DATA_W-2:0], mosi_lvl};
                    if (bit_cnt == LAST) begin
                        bit_cnt_n = '0;
                        state_n   = DONE;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
                if (sck_fall) begin
                    if (bit_cnt == '0) begin
                        tx_shift_n = buf_word;
                        consume    = 1'b1;
                    end else begin
                        tx_shift_n = {tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
                // A word completing on the same clock as CS rising is delivered; DONE then sees CS high.
                if (cs_rise && state_n != DONE) begin
                    frame_err_n = (bit_cnt_n != '0);
                    state_n     = IDLE;
                    bit_cnt_n   = '0;
                    tx_shift_n  = '0;
                end
            end
            DONE: begin
                rx_data_n  = rx_shift;
                rx_valid_n = 1'b1;
                state_n    = (cs_high || cs_rise) ? IDLE : SHIFT;
            end
            default: state_n = IDLE;
        endcase

        if (bus.rx_ack) begin
            if (pending) pending_n = 1'b0;
            else         overrun_n = 1'b0;
        end
        if (state == DONE) begin
            if (pending && !bus.rx_ack) overrun_n = 1'b1;
            pending_n = 1'b1;
        end

        if (consume) tx_ready_n = 1'b1;
        if (bus.tx_load && (tx_ready_q || consume)) begin
            tx_buf_n   = bus.tx_data;
            tx_ready_n = 1'b0;
        end
    end

    assign bus.MISO      = tx_shift[DATA_W-1];
    assign bus.tx_ready  = tx_ready_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state != IDLE);
endmodule
